// File: rtl/mem_arb_pkg.sv
// Shared definitions for the round-robin memory arbiter: default widths and the
// index-width helper used to size priority pointers and response tags.
package mem_arb_pkg;

   localparam int unsigned DEF_NR_PORTS    = 2;
   localparam int unsigned DEF_ADDR_WIDTH  = 64;
   localparam int unsigned DEF_DATA_WIDTH  = 64;
   localparam int unsigned DEF_USER_WIDTH  = 10;
   localparam int unsigned DEF_MEM_LATENCY = 1;

   // A single requester still needs a 1-bit index so every vector stays legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping modulo NR_PORTS.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter  int unsigned NR_PORTS = DEF_NR_PORTS,
   localparam int unsigned IDX_W    = idx_width(NR_PORTS)
) (
   input  logic [NR_PORTS-1:0] req,
   input  logic [IDX_W-1:0]    ptr,
   output logic                any,
   output logic [IDX_W-1:0]    idx
);

   int unsigned pos;

   // NOTE: every always_comb output gets a default before the loop, otherwise an
   // idle cycle would leave it unassigned and a latch would be inferred.
   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = 0;
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
         pos = 32'(ptr) + k;
         if (pos >= NR_PORTS) pos = pos - NR_PORTS;
         if (!any && req[IDX_W'(pos)]) begin
            any = 1'b1;
            idx = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NR_PORTS requesters; responses
// are routed back to their requester after a fixed MEM_LATENCY.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NR_PORTS    = DEF_NR_PORTS,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned USER_WIDTH  = DEF_USER_WIDTH,
   parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [NR_PORTS-1:0]                     req_i,
   input  logic [NR_PORTS-1:0]                     we_i,
   input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i,
   input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i,
   input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
   input  logic [NR_PORTS-1:0][USER_WIDTH-1:0]     wuser_i,
   output logic [NR_PORTS-1:0]                     gnt_o,
   output logic [NR_PORTS-1:0]                     rvalid_o,
   output logic [DATA_WIDTH-1:0]                   rdata_o,
   output logic [USER_WIDTH-1:0]                   ruser_o,
   output logic                                    req_o,
   input  logic                                    mem_gnt_i,
   output logic                                    we_o,
   output logic [ADDR_WIDTH-1:0]                   addr_o,
   output logic [DATA_WIDTH/8-1:0]                 be_o,
   output logic [DATA_WIDTH-1:0]                   data_o,
   output logic [USER_WIDTH-1:0]                   user_o,
   input  logic [DATA_WIDTH-1:0]                   data_i,
   input  logic [USER_WIDTH-1:0]                   user_i
);

   localparam int unsigned IDX_W = idx_width(NR_PORTS);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [BE_W-1:0]       be;
      logic [DATA_WIDTH-1:0] wdata;
      logic [USER_WIDTH-1:0] wuser;
   } port_req_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } resp_tag_t;

   logic                              any_req;
   logic [IDX_W-1:0]                  winner;
   logic [IDX_W-1:0]                  ptr_q;
   logic                              accept;
   port_req_t                         win_req;
   logic [MEM_LATENCY-1:0]            valid_q;
   logic [MEM_LATENCY-1:0][IDX_W-1:0] idx_q;
   resp_tag_t                         tail;

   rr_pick #(.NR_PORTS(NR_PORTS)) u_pick (
      .req (req_i),
      .ptr (ptr_q),
      .any (any_req),
      .idx (winner)
   );

   assign req_o  = any_req & ~rst_i;
   assign accept = req_o & mem_gnt_i;

   always_comb begin
      win_req = '0;
      if (req_o) begin
         win_req.we    = we_i[winner];
         win_req.addr  = addr_i[winner];
         win_req.be    = be_i[winner];
         win_req.wdata = wdata_i[winner];
         win_req.wuser = wuser_i[winner];
      end
   end

   assign we_o   = win_req.we;
   assign addr_o = win_req.addr;
   assign be_o   = win_req.be;
   assign data_o = win_req.wdata;
   assign user_o = win_req.wuser;

   always_comb begin
      gnt_o = '0;
      if (accept) gnt_o[winner] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (winner == IDX_W'(NR_PORTS - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= accept;
         for (int unsigned i = 1; i < MEM_LATENCY; i++) valid_q[i] <= valid_q[i-1];
      end
   end

   // NOTE: the tag indices are qualified by valid_q, so they carry no reset;
   // only control state that can raise an output is cleared.
   always_ff @(posedge clk_i) begin
      idx_q[0] <= winner;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) idx_q[i] <= idx_q[i-1];
   end

   assign tail = '{valid: valid_q[MEM_LATENCY-1], idx: idx_q[MEM_LATENCY-1]};

   always_comb begin
      rvalid_o = '0;
      if (tail.valid) rvalid_o[tail.idx] = 1'b1;
   end

   assign rdata_o = data_i;
   assign ruser_o = user_i;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench: a 2-port/latency-1 and a 4-port/latency-2 arbiter driven side by side.
module tb_mem_rr_arbiter;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      int port;
      int due;
   } exp_t;

   exp_t q2[$];
   exp_t q4[$];
   exp_t e2, e4;
   int   ptr2 = 0;
   int   ptr4 = 0;

   // 2-port, latency 1, default widths
   logic              rst2, mgnt2, req_o2, we_o2;
   logic [1:0]        req2, we2, gnt2, rvalid2;
   logic [1:0][63:0]  addr2, wdata2;
   logic [1:0][7:0]   be2;
   logic [1:0][9:0]   wuser2;
   logic [63:0]       rdata2, addr_o2, data_o2, data_i2;
   logic [9:0]        ruser2, user_o2, user_i2;
   logic [7:0]        be_o2;

   // 4-port, latency 2, narrower widths
   logic              rst4, mgnt4, req_o4, we_o4;
   logic [3:0]        req4, we4, gnt4, rvalid4;
   logic [3:0][31:0]  addr4, wdata4;
   logic [3:0][3:0]   be4;
   logic [3:0][7:0]   wuser4;
   logic [31:0]       rdata4, addr_o4, data_o4, data_i4;
   logic [7:0]        ruser4, user_o4, user_i4;
   logic [3:0]        be_o4;

   mem_rr_arbiter dut2 (
      .clk_i(clk_i), .rst_i(rst2), .req_i(req2), .we_i(we2), .addr_i(addr2), .be_i(be2),
      .wdata_i(wdata2), .wuser_i(wuser2), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
      .ruser_o(ruser2), .req_o(req_o2), .mem_gnt_i(mgnt2), .we_o(we_o2), .addr_o(addr_o2),
      .be_o(be_o2), .data_o(data_o2), .user_o(user_o2), .data_i(data_i2), .user_i(user_i2)
   );

   mem_rr_arbiter #(
      .NR_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(8), .MEM_LATENCY(2)
   ) dut4 (
      .clk_i(clk_i), .rst_i(rst4), .req_i(req4), .we_i(we4), .addr_i(addr4), .be_i(be4),
      .wdata_i(wdata4), .wuser_i(wuser4), .gnt_o(gnt4), .rvalid_o(rvalid4), .rdata_o(rdata4),
      .ruser_o(ruser4), .req_o(req_o4), .mem_gnt_i(mgnt4), .we_o(we_o4), .addr_o(addr_o4),
      .be_o(be_o4), .data_o(data_o4), .user_o(user_o4), .data_i(data_i4), .user_i(user_i4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [3:0] req, input int ptr, input int n);
      for (int k = 0; k < n; k++) begin
         int j;
         j = (ptr + k) % n;
         if (req[j]) return j;
      end
      return 0;
   endfunction

   // One clock of stimulus for both DUTs; arbitration checked mid-cycle.
   task automatic step(input logic [1:0] r2, input logic g2, input logic s2,
                       input logic [3:0] r4, input logic g4, input logic s4);
      int   w2, w4;
      logic v2, v4, a2, a4;
      @(posedge clk_i);
      #1;
      req2 = r2; mgnt2 = g2; rst2 = s2;
      req4 = r4; mgnt4 = g4; rst4 = s4;
      data_i2 = {$urandom, $urandom}; user_i2 = 10'($urandom);
      data_i4 = $urandom;             user_i4 = 8'($urandom);
      v2 = (r2 != 0) && !s2; a2 = v2 && g2; w2 = pick({2'b00, r2}, ptr2, 2);
      v4 = (r4 != 0) && !s4; a4 = v4 && g4; w4 = pick(r4, ptr4, 4);
      if (a2) q2.push_back('{w2, cyc + 1});
      if (a4) q4.push_back('{w4, cyc + 2});
      @(negedge clk_i);
      check("req_o2",  64'(req_o2),  64'(v2));
      check("gnt2",    64'(gnt2),    a2 ? 64'(1) << w2 : 64'(0));
      check("addr_o2", addr_o2,      v2 ? addr2[w2] : 64'(0));
      check("we_o2",   64'(we_o2),   v2 ? 64'(we2[w2]) : 64'(0));
      check("be_o2",   64'(be_o2),   v2 ? 64'(be2[w2]) : 64'(0));
      check("data_o2", data_o2,      v2 ? wdata2[w2] : 64'(0));
      check("user_o2", 64'(user_o2), v2 ? 64'(wuser2[w2]) : 64'(0));
      check("req_o4",  64'(req_o4),  64'(v4));
      check("gnt4",    64'(gnt4),    a4 ? 64'(1) << w4 : 64'(0));
      check("addr_o4", 64'(addr_o4), v4 ? 64'(addr4[w4]) : 64'(0));
      check("we_o4",   64'(we_o4),   v4 ? 64'(we4[w4]) : 64'(0));
      check("be_o4",   64'(be_o4),   v4 ? 64'(be4[w4]) : 64'(0));
      check("data_o4", 64'(data_o4), v4 ? 64'(wdata4[w4]) : 64'(0));
      check("user_o4", 64'(user_o4), v4 ? 64'(wuser4[w4]) : 64'(0));
      if (s2) begin
         ptr2 = 0;
         while (q2.size() > 0 && q2[$].due > cyc) void'(q2.pop_back());
      end else if (a2) ptr2 = (w2 + 1) % 2;
      if (s4) begin
         ptr4 = 0;
         while (q4.size() > 0 && q4[$].due > cyc) void'(q4.pop_back());
      end else if (a4) ptr4 = (w4 + 1) % 4;
   endtask

   always @(negedge clk_i) begin
      if (mon_en) begin
         if (rvalid2 != '0) begin
            if (q2.size() == 0) check("rv2_unexpected", 64'(rvalid2), 64'(0));
            else begin
               e2 = q2.pop_front();
               check("rvalid2",     64'(rvalid2), 64'(1) << e2.port);
               check("rv2_latency", 64'(cyc),     64'(e2.due));
               check("rdata2",      rdata2,       data_i2);
               check("ruser2",      64'(ruser2),  64'(user_i2));
            end
         end else if (q2.size() > 0 && q2[0].due <= cyc) begin
            check("rv2_missing", 64'(rvalid2), 64'(1) << q2[0].port);
            void'(q2.pop_front());
         end
         if (rvalid4 != '0) begin
            if (q4.size() == 0) check("rv4_unexpected", 64'(rvalid4), 64'(0));
            else begin
               e4 = q4.pop_front();
               check("rvalid4",     64'(rvalid4), 64'(1) << e4.port);
               check("rv4_latency", 64'(cyc),     64'(e4.due));
               check("rdata4",      64'(rdata4),  64'(data_i4));
               check("ruser4",      64'(ruser4),  64'(user_i4));
            end
         end else if (q4.size() > 0 && q4[0].due <= cyc) begin
            check("rv4_missing", 64'(rvalid4), 64'(1) << q4[0].port);
            void'(q4.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst2 = 1'b1; rst4 = 1'b1; req2 = '0; req4 = '0; mgnt2 = 1'b1; mgnt4 = 1'b1;
      data_i2 = '0; user_i2 = '0; data_i4 = '0; user_i4 = '0;
      we2 = '0; we4 = '0;
      addr2[0] = 64'h100; addr2[1] = 64'h200;
      for (int p = 0; p < 2; p++) begin
         be2[p] = 8'hFF; wdata2[p] = {$urandom, $urandom}; wuser2[p] = 10'($urandom);
      end
      for (int p = 0; p < 4; p++) begin
         addr4[p] = 32'h1000 + 32'(p) * 32'h40; be4[p] = 4'hF;
         wdata4[p] = $urandom; wuser4[p] = 8'($urandom);
      end

      // Reset holds req_o/gnt_o low even with requests pending.
      step(2'b11, 1, 1, 4'b1111, 1, 1);
      step(2'b11, 1, 1, 4'b1111, 1, 1);
      check("reset_rvalid2", 64'(rvalid2), 64'(0));
      check("reset_rvalid4", 64'(rvalid4), 64'(0));
      mon_en = 1'b1;

      // Single read from port 0.
      step(2'b01, 1, 0, 4'b0000, 1, 0);
      step(2'b00, 1, 0, 4'b0000, 1, 0);

      // Both ports held: alternating grants from a fresh reset.
      step(2'b00, 1, 1, 4'b0000, 1, 0);
      repeat (4) step(2'b11, 1, 0, 4'b0000, 1, 0);
      step(2'b00, 1, 0, 4'b0000, 1, 0);

      // Memory stall on port 1, then accept.
      repeat (3) step(2'b10, 0, 0, 4'b0000, 1, 0);
      step(2'b10, 1, 0, 4'b0000, 1, 0);

      // Back-to-back accepts of ports 2, 0, 3 on the latency-2 arbiter.
      step(2'b00, 1, 0, 4'b0100, 1, 0);
      step(2'b00, 1, 0, 4'b0001, 1, 0);
      step(2'b00, 1, 0, 4'b1000, 1, 0);
      repeat (3) step(2'b00, 1, 0, 4'b0000, 1, 0);

      // Write from port 1 produces one ack.
      we2[1] = 1'b1; be2[1] = 8'hF0; wdata2[1] = 64'hDEAD;
      step(2'b10, 1, 0, 4'b0000, 1, 0);
      step(2'b00, 1, 0, 4'b0000, 1, 0);
      we2[1] = 1'b0; be2[1] = 8'hFF;

      // Reset right after an accept; the latency-2 response must be dropped.
      step(2'b01, 1, 0, 4'b0010, 1, 0);
      step(2'b00, 1, 1, 4'b0000, 1, 1);
      step(2'b11, 1, 0, 4'b1111, 1, 0);
      check("rst_drop4", 64'(rvalid4), 64'(0));

      // Random traffic with random memory stalls.
      for (int n = 0; n < 40; n++) begin
         for (int p = 0; p < 2; p++) begin
            we2[p] = 1'($urandom); addr2[p] = {$urandom, $urandom}; be2[p] = 8'($urandom);
            wdata2[p] = {$urandom, $urandom}; wuser2[p] = 10'($urandom);
         end
         for (int p = 0; p < 4; p++) begin
            we4[p] = 1'($urandom); addr4[p] = $urandom; be4[p] = 4'($urandom);
            wdata4[p] = $urandom; wuser4[p] = 8'($urandom);
         end
         step(2'($urandom), ($urandom_range(3) != 0), 0, 4'($urandom), ($urandom_range(3) != 0), 0);
      end

      repeat (4) step(2'b00, 1, 0, 4'b0000, 1, 0);
      check("drain_q2", 64'(q2.size()), 64'(0));
      check("drain_q4", 64'(q4.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
